// File: rtl/cpu_memory.sv
// cpu_memory: memory stage of the mox125 pipeline.
// Performs data-memory loads/stores as a Wishbone-classic master, stalls
// execute while an access is outstanding, and hands register writeback to
// the next stage. Non-memory ops pass through with one cycle of latency.
// Optional build macro: CPU_MEMORY_BUS_TIMEOUT_EN (bus-timeout abort with
// a one-cycle bus_error_o pulse).
module cpu_memory #(
   parameter int PCB_WIDTH      = 5,
   parameter int PCB_WA         = 0,
   parameter int PCB_WB         = 1,
   parameter int PCB_RM         = 2,
   parameter int PCB_WM         = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
   input  logic [3:0]           register0_write_index_i,
   input  logic [3:0]           register1_write_index_i,
   input  logic [31:0]          memory_address_i,
   input  logic [31:0]          reg0_result_i,
   input  logic [31:0]          reg1_result_i,
   input  logic [31:0]          mem_result_i,
   input  logic [1:0]           mem_size_i,
   output logic                 stall_o,
   output logic [31:0]          dwb_adr_o,
   output logic [31:0]          dwb_dat_o,
   input  logic [31:0]          dwb_dat_i,
   output logic [3:0]           dwb_sel_o,
   output logic                 dwb_we_o,
   output logic                 dwb_cyc_o,
   output logic                 dwb_stb_o,
   input  logic                 dwb_ack_i,
   output logic                 register_wea_o,
   output logic                 register_web_o,
   output logic [3:0]           register0_write_index_o,
   output logic [3:0]           register1_write_index_o,
   output logic [31:0]          reg0_result_o,
   output logic [31:0]          reg1_result_o,
   output logic                 bus_error_o
);

   typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

   state_t state_q, state_d;

   // Instruction fields latched at issue; execute may move on once we ack.
   logic        wa_q, wb_q, wa_d, wb_d;
   logic [3:0]  idx0_q, idx1_q, idx0_d, idx1_d;
   logic [31:0] r0_q, r1_q, r0_d, r1_d;
   logic [1:0]  alo_q, alo_d;
   logic [1:0]  size_q, size_d;

   // Next values of the registered outputs.
   logic        cyc_d, stb_d, we_d;
   logic [31:0] adr_d, dat_d;
   logic [3:0]  sel_d;
   logic        wea_d, web_d;
   logic [3:0]  oidx0_d, oidx1_d;
   logic [31:0] or0_d, or1_d;

   logic [3:0]  issue_sel;
   logic [31:0] issue_dat;
   logic [31:0] rd_lane;
   logic        is_mem;

   // Only the WA/WB/RM/WM bits carry meaning here.
   logic        unused_pcb;
   assign unused_pcb = ^pipeline_control_bits_i;

   assign is_mem = pipeline_control_bits_i[PCB_RM] | pipeline_control_bits_i[PCB_WM];

`ifdef CPU_MEMORY_BUS_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];
   logic [7:0] tmo_q, tmo_d;
   logic       berr_d;
`endif

   // Big-endian byte selects and lane-replicated store data for the op being issued.
   always_comb begin
      issue_sel = 4'b1111;
      issue_dat = mem_result_i;
      case (mem_size_i)
         2'b00: begin
            issue_sel = 4'b1000 >> memory_address_i[1:0];
            issue_dat = {4{mem_result_i[7:0]}};
         end
         2'b01: begin
            issue_sel = memory_address_i[1] ? 4'b0011 : 4'b1100;
            issue_dat = {2{mem_result_i[15:0]}};
         end
         default: begin
            issue_sel = 4'b1111;
            issue_dat = mem_result_i;
         end
      endcase
   end

   // Zero-extended read lane chosen by the latched size and address bits.
   always_comb begin
      rd_lane = dwb_dat_i;
      case (size_q)
         2'b00: begin
            case (alo_q)
               2'd0:    rd_lane = {24'd0, dwb_dat_i[31:24]};
               2'd1:    rd_lane = {24'd0, dwb_dat_i[23:16]};
               2'd2:    rd_lane = {24'd0, dwb_dat_i[15:8]};
               default: rd_lane = {24'd0, dwb_dat_i[7:0]};
            endcase
         end
         2'b01:   rd_lane = alo_q[1] ? {16'd0, dwb_dat_i[15:0]} : {16'd0, dwb_dat_i[31:16]};
         default: rd_lane = dwb_dat_i;
      endcase
   end

   // Next-state and next-output logic for the IDLE/BUS controller.
   always_comb begin
      state_d = state_q;
      wa_d    = wa_q;
      wb_d    = wb_q;
      idx0_d  = idx0_q;
      idx1_d  = idx1_q;
      r0_d    = r0_q;
      r1_d    = r1_q;
      alo_d   = alo_q;
      size_d  = size_q;
      cyc_d   = dwb_cyc_o;
      stb_d   = dwb_stb_o;
      we_d    = dwb_we_o;
      adr_d   = dwb_adr_o;
      sel_d   = dwb_sel_o;
      dat_d   = dwb_dat_o;
      wea_d   = 1'b0;
      web_d   = 1'b0;
      oidx0_d = register0_write_index_o;
      oidx1_d = register1_write_index_o;
      or0_d   = reg0_result_o;
      or1_d   = reg1_result_o;
`ifdef CPU_MEMORY_BUS_TIMEOUT_EN
      tmo_d   = tmo_q;
      berr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (!flush_i) begin
               if (is_mem) begin
                  wa_d    = pipeline_control_bits_i[PCB_WA];
                  wb_d    = pipeline_control_bits_i[PCB_WB];
                  idx0_d  = register0_write_index_i;
                  idx1_d  = register1_write_index_i;
                  r0_d    = reg0_result_i;
                  r1_d    = reg1_result_i;
                  alo_d   = memory_address_i[1:0];
                  size_d  = mem_size_i;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
                  // RM+WM together resolves to a write.
                  we_d    = pipeline_control_bits_i[PCB_WM];
                  adr_d   = {memory_address_i[31:2], 2'b00};
                  sel_d   = issue_sel;
                  dat_d   = issue_dat;
                  state_d = BUS;
`ifdef CPU_MEMORY_BUS_TIMEOUT_EN
                  tmo_d   = 8'd0;
`endif
               end else begin
                  wea_d   = pipeline_control_bits_i[PCB_WA];
                  web_d   = pipeline_control_bits_i[PCB_WB];
                  oidx0_d = register0_write_index_i;
                  oidx1_d = register1_write_index_i;
                  or0_d   = reg0_result_i;
                  or1_d   = reg1_result_i;
               end
            end
         end
         BUS: begin
            // flush_i is ignored here: the in-flight op is older than the flusher.
            if (dwb_ack_i) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               state_d = IDLE;
               wea_d   = wa_q;
               web_d   = wb_q;
               oidx0_d = idx0_q;
               oidx1_d = idx1_q;
               // Stores keep the execute result (push/jsr update $sp).
               or0_d   = dwb_we_o ? r0_q : rd_lane;
               or1_d   = r1_q;
            end else begin
`ifdef CPU_MEMORY_BUS_TIMEOUT_EN
               tmo_d = tmo_q + 8'd1;
               if (tmo_d == TIMEOUT_LIM) begin
                  cyc_d   = 1'b0;
                  stb_d   = 1'b0;
                  we_d    = 1'b0;
                  berr_d  = 1'b1;
                  state_d = IDLE;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, latched instruction and all registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q                 <= IDLE;
         stall_o                 <= 1'b0;
         wa_q                    <= 1'b0;
         wb_q                    <= 1'b0;
         idx0_q                  <= 4'd0;
         idx1_q                  <= 4'd0;
         r0_q                    <= 32'd0;
         r1_q                    <= 32'd0;
         alo_q                   <= 2'd0;
         size_q                  <= 2'd0;
         dwb_cyc_o               <= 1'b0;
         dwb_stb_o               <= 1'b0;
         dwb_we_o                <= 1'b0;
         dwb_adr_o               <= 32'd0;
         dwb_sel_o               <= 4'd0;
         dwb_dat_o               <= 32'd0;
         register_wea_o          <= 1'b0;
         register_web_o          <= 1'b0;
         register0_write_index_o <= 4'd0;
         register1_write_index_o <= 4'd0;
         reg0_result_o           <= 32'd0;
         reg1_result_o           <= 32'd0;
      end else begin
         state_q                 <= state_d;
         stall_o                 <= (state_d == BUS);
         wa_q                    <= wa_d;
         wb_q                    <= wb_d;
         idx0_q                  <= idx0_d;
         idx1_q                  <= idx1_d;
         r0_q                    <= r0_d;
         r1_q                    <= r1_d;
         alo_q                   <= alo_d;
         size_q                  <= size_d;
         dwb_cyc_o               <= cyc_d;
         dwb_stb_o               <= stb_d;
         dwb_we_o                <= we_d;
         dwb_adr_o               <= adr_d;
         dwb_sel_o               <= sel_d;
         dwb_dat_o               <= dat_d;
         register_wea_o          <= wea_d;
         register_web_o          <= web_d;
         register0_write_index_o <= oidx0_d;
         register1_write_index_o <= oidx1_d;
         reg0_result_o           <= or0_d;
         reg1_result_o           <= or1_d;
      end
   end

`ifdef CPU_MEMORY_BUS_TIMEOUT_EN
   // Timeout counter and the one-cycle error pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_q       <= 8'd0;
         bus_error_o <= 1'b0;
      end else begin
         tmo_q       <= tmo_d;
         bus_error_o <= berr_d;
      end
   end
`else
   assign bus_error_o = 1'b0;
`endif

endmodule
